// File: rtl/frame_buf_sched_pkg.sv
// fb_pkg: shared types and helpers for the frame-buffer scheduler (FB_RD_PRIO_EN selects read-priority arbitration)
package fb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} fb_state_e;
  typedef enum logic {CL_RD, CL_WR} fb_client_e;
  typedef logic [1:0] fb_idx_t;
  localparam int NUM_BUF = 3;
  // the three indices 0,1,2 xor to 3, so the missing one is 3^a^b
  function automatic fb_idx_t fb_free_idx(fb_idx_t a, fb_idx_t b);
    return fb_idx_t'(2'd3 ^ a ^ b);
  endfunction
endpackage

// File: rtl/frame_buf_sched_rr_arb2.sv
// fb_rr_arb2: two-client arbiter, round-robin by last grant or fixed read priority under FB_RD_PRIO_EN
module fb_rr_arb2
  import fb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_req_rd,
  input  logic i_req_wr,
  input  logic i_upd,
  output logic o_gnt_rd,
  output logic o_gnt_wr
);
`ifdef FB_RD_PRIO_EN
  logic w_unused;
  assign w_unused = ^{clk, rst_n, i_upd};
  assign o_gnt_rd = i_req_rd;
  assign o_gnt_wr = i_req_wr & ~i_req_rd;
`else
  fb_client_e r_last;
  // starting as if write won last lets read take the first tie
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_last <= CL_WR;
    else if (i_upd) r_last <= o_gnt_wr ? CL_WR : CL_RD;
  assign o_gnt_rd = i_req_rd & (~i_req_wr | (r_last == CL_WR));
  assign o_gnt_wr = i_req_wr & (~i_req_rd | (r_last == CL_RD));
`endif
endmodule

// File: rtl/frame_buf_sched.sv
// frame_buf_sched: triple-buffer scheduler arbitrating camera writes and LCD reads onto one AXI command port (FB_RD_PRIO_EN: read priority)
module frame_buf_sched
  import fb_pkg::*;
#(
  parameter int              ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              FRAME_BYTES = 768000,
  parameter int              BURST_LEN   = 16,
  parameter int              DATA_BYTES  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic              wr_sof,
  input  logic              rd_req,
  input  logic              rd_sof,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_len,
  input  logic              cmd_done,
  output logic              wr_grant,
  output logic              rd_grant,
  output logic [1:0]        wr_buf_idx,
  output logic [1:0]        rd_buf_idx
);
  localparam logic [ADDR_W-1:0] FB = ADDR_W'(FRAME_BYTES);
  localparam logic [ADDR_W-1:0] BB = ADDR_W'(BURST_LEN * DATA_BYTES);

  function automatic logic [ADDR_W-1:0] buf_base(fb_idx_t idx);
    return BASE_ADDR + ADDR_W'(idx) * FB;
  endfunction

  fb_state_e         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_wr_off, r_rd_off, r_cmd_addr;
  fb_idx_t           r_wbuf, r_rbuf, r_latest;
  logic              r_latest_vld, r_wr_pend, r_rd_pend, r_cmd_write, r_wr_grant, r_rd_grant;
  logic              w_gnt_rd, w_gnt_wr, w_apply, w_load, w_hs;
  logic              w_wr_swap, w_lv_a, w_rd_take;
  fb_idx_t           w_latest_a, w_wbuf_a, w_rbuf_a;

  fb_rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req_rd (rd_req & (r_rd_off != FB)),
    .i_req_wr (wr_req & (r_wr_off != FB)),
    .i_upd    (w_load),
    .o_gnt_rd (w_gnt_rd),
    .o_gnt_wr (w_gnt_wr)
  );

  assign w_apply = (r_state == IDLE) & (r_wr_pend | r_rd_pend);
  assign w_load  = (r_state == IDLE) & ~w_apply & (w_gnt_rd | w_gnt_wr);
  assign w_hs    = (r_state == ISSUE) & cmd_ready;

  always_comb
    w_state_nxt = w_load ? ISSUE :
                  w_hs ? WAIT :
                  ((r_state == WAIT) & cmd_done) ? IDLE : r_state;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;

  // wr sof resolves first so a rd sof in the same cycle can pick up the frame it just closed
  assign w_wr_swap  = r_wr_pend & (r_wr_off != '0);
  assign w_latest_a = w_wr_swap ? r_wbuf : r_latest;
  assign w_lv_a     = w_wr_swap | r_latest_vld;
  assign w_wbuf_a   = w_wr_swap ? fb_free_idx(r_wbuf, r_rbuf) : r_wbuf;
  assign w_rd_take  = r_rd_pend & w_lv_a;
  assign w_rbuf_a   = w_rd_take ? w_latest_a : r_rbuf;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_off     <= '0;
      r_rd_off     <= '0;
      r_cmd_addr   <= '0;
      r_cmd_write  <= 1'b0;
      r_wbuf       <= '0;
      r_rbuf       <= fb_idx_t'(NUM_BUF - 1);
      r_latest     <= '0;
      r_latest_vld <= 1'b0;
      r_wr_pend    <= 1'b0;
      r_rd_pend    <= 1'b0;
      r_wr_grant   <= 1'b0;
      r_rd_grant   <= 1'b0;
    end else begin
      r_wr_pend  <= wr_sof | (r_wr_pend & ~w_apply);
      r_rd_pend  <= rd_sof | (r_rd_pend & ~w_apply);
      r_wr_grant <= w_hs & r_cmd_write;
      r_rd_grant <= w_hs & ~r_cmd_write;
      if (w_apply) begin
        r_latest     <= w_latest_a;
        r_latest_vld <= w_lv_a & ~w_rd_take;
        r_wbuf       <= w_wbuf_a;
        r_rbuf       <= w_rbuf_a;
        if (r_wr_pend) r_wr_off <= '0;
        if (r_rd_pend) r_rd_off <= '0;
      end
      if (w_load) begin
        r_cmd_write <= w_gnt_wr;
        r_cmd_addr  <= w_gnt_wr ? buf_base(r_wbuf) + r_wr_off : buf_base(r_rbuf) + r_rd_off;
      end
      if (w_hs) begin
        if (r_cmd_write) r_wr_off <= r_wr_off + BB;
        else r_rd_off <= r_rd_off + BB;
      end
    end

  assign cmd_valid  = (r_state == ISSUE);
  assign cmd_write  = r_cmd_write;
  assign cmd_addr   = r_cmd_addr;
  assign cmd_len    = 8'(BURST_LEN - 1);
  assign wr_grant   = r_wr_grant;
  assign rd_grant   = r_rd_grant;
  assign wr_buf_idx = r_wbuf;
  assign rd_buf_idx = r_rbuf;
endmodule

// File: tb/tb_frame_buf_sched.sv
// tb_frame_buf_sched: directed and randomized checks of frame_buf_sched against a transaction-level buffer model
module tb_frame_buf_sched;
  localparam int FRAME = 768000;
  localparam int BB    = 256;

  logic clk = 0, rst_n = 0, wr_req = 0, wr_sof = 0, rd_req = 0, rd_sof = 0, cmd_ready = 0, cmd_done = 0;
  logic cmd_valid, cmd_write, wr_grant, rd_grant;
  logic [31:0] cmd_addr;
  logic [7:0] cmd_len;
  logic [1:0] wr_buf_idx, rd_buf_idx;

  always #5 clk = ~clk;

  frame_buf_sched dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_sof(wr_sof), .rd_req(rd_req), .rd_sof(rd_sof),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_done(cmd_done), .wr_grant(wr_grant), .rd_grant(rd_grant),
    .wr_buf_idx(wr_buf_idx), .rd_buf_idx(rd_buf_idx)
  );

  int checks = 0, errors = 0;
  int m_wbuf, m_rbuf, m_latest, m_wr_off, m_rd_off;
  bit m_lv, m_last_wr;
  bit m_pend_q[$];
  bit exp_write, busy, spur_done;
  logic [31:0] exp_addr;
  int done_cnt, ncmd, stall, ready_pct, done_min, done_max;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_wbuf = 0; m_rbuf = 2; m_latest = 0; m_lv = 0; m_wr_off = 0; m_rd_off = 0;
    m_last_wr = 1; m_pend_q.delete(); busy = 0; exp_write = 0; exp_addr = 0; stall = 0;
  endfunction

  // sof semantics written directly from the buffer-ownership rules
  function automatic void m_apply(bit is_wr);
    if (is_wr) begin
      if (m_wr_off != 0) begin
        m_latest = m_wbuf;
        m_lv = 1;
        m_wbuf = 3 - m_latest - m_rbuf;
      end
      m_wr_off = 0;
    end else begin
      if (m_lv) begin
        m_rbuf = m_latest;
        m_lv = 0;
      end
      m_rd_off = 0;
    end
  endfunction

  task automatic cycle();
    bit p_wr, p_rd, p_ws, p_rs, p_rdy, p_dn, p_v, hs, mw, mr, pick_wr;
    p_wr = wr_req; p_rd = rd_req; p_ws = wr_sof; p_rs = rd_sof;
    p_rdy = cmd_ready; p_dn = cmd_done; p_v = cmd_valid;
    @(posedge clk); #1;
    wr_sof = 0; rd_sof = 0; cmd_done = 0;
    hs = p_v && p_rdy;
    chk("wr_grant", wr_grant, hs && exp_write);
    chk("rd_grant", rd_grant, hs && !exp_write);
    if (hs) begin
      if (exp_write) m_wr_off += BB; else m_rd_off += BB;
      busy = 1;
      done_cnt = $urandom_range(done_max, done_min);
    end else if (p_dn && busy) busy = 0;
    if (!p_v && cmd_valid) begin
      chk("idle_at_issue", busy, 0);
      while (m_pend_q.size() > 0) m_apply(m_pend_q.pop_front());
      mw = p_wr && m_wr_off < FRAME;
      mr = p_rd && m_rd_off < FRAME;
      chk("req_present", mw || mr, 1);
`ifdef FB_RD_PRIO_EN
      pick_wr = !mr;
`else
      pick_wr = (mw && mr) ? !m_last_wr : mw;
`endif
      m_last_wr = pick_wr;
      exp_write = pick_wr;
      exp_addr = pick_wr ? 32'(m_wbuf * FRAME + m_wr_off) : 32'(m_rbuf * FRAME + m_rd_off);
      ncmd++;
      chk("wr_buf_idx", wr_buf_idx, m_wbuf);
      chk("rd_buf_idx", rd_buf_idx, m_rbuf);
      chk("cmd_len", cmd_len, 15);
    end
    if (p_v && !p_rdy) chk("valid_hold", cmd_valid, 1);
    if (hs) chk("valid_drop", cmd_valid, 0);
    if (cmd_valid) begin
      chk("cmd_write", cmd_write, exp_write);
      chk("cmd_addr", cmd_addr, exp_addr);
    end
    if (p_ws) m_pend_q.push_back(1);
    if (p_rs) m_pend_q.push_back(0);
    if (!cmd_valid && !busy && ((p_wr && m_wr_off < FRAME) || (p_rd && m_rd_off < FRAME))) stall++;
    else stall = 0;
    chk("liveness", stall > 8, 0);
    if (stall > 8) stall = 0;
    if (busy) begin
      if (done_cnt == 0) cmd_done = 1; else done_cnt--;
    end else if (spur_done) cmd_done = ($urandom_range(9, 0) == 0);
    cmd_ready = ($urandom_range(99, 0) < ready_pct);
  endtask

  task automatic run_cmds(input int n, input int budget);
    int target, c;
    target = ncmd + n;
    c = 0;
    while (ncmd < target && c < budget) begin
      cycle();
      c++;
    end
    chk("cmd_timeout", ncmd >= target, 1);
  endtask

  initial begin
    int c;
    m_reset();
    ncmd = 0; ready_pct = 100; done_min = 0; done_max = 0; spur_done = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_write", cmd_write, 0);
    chk("rst_addr", cmd_addr, 0);
    chk("rst_len", cmd_len, 15);
    chk("rst_wgrant", wr_grant, 0);
    chk("rst_rgrant", rd_grant, 0);
    chk("rst_wbuf", wr_buf_idx, 0);
    chk("rst_rbuf", rd_buf_idx, 2);

    rd_req = 1;
    cmd_ready = 1;
    @(negedge clk) rst_n = 1;
    run_cmds(1, 20);
    chk("t1_write", cmd_write, 0);
    chk("t1_addr", cmd_addr, 32'h177000);
    chk("t1_len", cmd_len, 15);
    run_cmds(1, 20);
    chk("t1_addr2", cmd_addr, 32'h177100);

    wr_req = 1;
    for (int i = 0; i < 4; i++) begin
      run_cmds(1, 20);
`ifdef FB_RD_PRIO_EN
      chk("t2_rd_prio", cmd_write, 0);
`else
      chk("t2_alt", cmd_write, i % 2 == 0);
      if (i == 0) chk("t2_waddr0", cmd_addr, 32'h0);
      if (i == 2) chk("t2_waddr1", cmd_addr, 32'h100);
`endif
    end

    rd_req = 0;
    c = 0;
    while (m_wr_off < FRAME && c < 20000) begin
      cycle();
      c++;
    end
    chk("t3_timeout", c < 20000, 1);
    repeat (20) begin
      cycle();
      chk("t3_masked", cmd_valid, 0);
    end
    wr_sof = 1;
    run_cmds(1, 30);
    chk("t3_wbuf", wr_buf_idx, 1);
    chk("t3_waddr", cmd_addr, 32'hBB800);
    chk("t3_wr", cmd_write, 1);
    wr_req = 0;
    rd_req = 1;
    rd_sof = 1;
    run_cmds(1, 30);
    chk("t3_rbuf", rd_buf_idx, 0);
    chk("t3_raddr", cmd_addr, 32'h0);

    rd_req = 0;
    wr_req = 1;
    done_min = 4; done_max = 4;
    c = 0;
    while (!(busy && exp_write) && c < 50) begin
      cycle();
      c++;
    end
    chk("t4_reach_wait", busy && exp_write, 1);
    wr_sof = 1;
    cycle();
    chk("t4_inflight", cmd_addr, exp_addr);
    chk("t4_deferred", wr_buf_idx, 1);
    run_cmds(1, 30);
    chk("t4_wbuf", wr_buf_idx, 2);
    chk("t4_waddr", cmd_addr, 32'h177000);

    done_min = 0; done_max = 0;
    wr_req = 0;
    rd_req = 1;
    rd_sof = 1;
    run_cmds(1, 30);
    chk("t5_rbuf", rd_buf_idx, 1);
    chk("t5_raddr", cmd_addr, 32'hBB800);
    run_cmds(1, 30);
    chk("t5_raddr2", cmd_addr, 32'hBB900);
    rd_sof = 1;
    run_cmds(1, 30);
    chk("t5_rbuf_same", rd_buf_idx, 1);
    chk("t5_restart", cmd_addr, 32'hBB800);

    ready_pct = 70; done_min = 0; done_max = 3; spur_done = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3, 0) == 0) begin
        wr_req = $urandom_range(1, 0);
        rd_req = $urandom_range(1, 0);
      end
      if (m_pend_q.size() == 0 && $urandom_range(39, 0) == 0) begin
        if ($urandom_range(1, 0) == 1) wr_sof = 1; else rd_sof = 1;
      end
      cycle();
    end

    spur_done = 0;
    ready_pct = 0;
    done_max = 0;
    wr_req = 0;
    rd_req = 1;
    c = 0;
    while (!cmd_valid && c < 100) begin
      cycle();
      c++;
    end
    chk("t7_in_issue", cmd_valid, 1);
    #3 rst_n = 0;
    #1;
    chk("t7_valid", cmd_valid, 0);
    chk("t7_write", cmd_write, 0);
    chk("t7_addr", cmd_addr, 0);
    chk("t7_len", cmd_len, 15);
    chk("t7_wgrant", wr_grant, 0);
    chk("t7_rgrant", rd_grant, 0);
    chk("t7_wbuf", wr_buf_idx, 0);
    chk("t7_rbuf", rd_buf_idx, 2);
    m_reset();
    cmd_ready = 0;
    cmd_done = 0;
    @(negedge clk);
    @(negedge clk) rst_n = 1;
    ready_pct = 100;
    run_cmds(1, 20);
    chk("t7_addr_after", cmd_addr, 32'h177000);
    run_cmds(1, 20);
    chk("t7_addr_next", cmd_addr, 32'h177100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
